// File: rtl/aftab_memory_byte_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// aftab_memory_byte_sequencer_pkg
//   Shared definitions for the AFTAB byte-wide memory sequencer:
//     - request size codes (byte / half / word; code 2'b11 behaves as word)
//     - FSM state encodings (IDLE, ACCESS, RELEASE, FINISH)
//     - default ready-wait limit used by the optional timeout logic
//     - byteCount(): number of byte transfers for a size code
// ---------------------------------------------------------------------------
package aftab_memory_byte_sequencer_pkg;

  // Request size codes
  localparam logic [1:0] sizeByte = 2'b00;
  localparam logic [1:0] sizeHalf = 2'b01;
  localparam logic [1:0] sizeWord = 2'b10;

  // FSM state encodings
  localparam logic [1:0] stateIdle    = 2'd0;
  localparam logic [1:0] stateAccess  = 2'd1;
  localparam logic [1:0] stateRelease = 2'd2;
  localparam logic [1:0] stateFinish  = 2'd3;

  // Default number of cycles to wait on each handshake phase
  localparam int defaultTimeoutCycles = 64;

  // Number of sequential byte accesses for a size code
  function automatic logic [2:0] byteCount(input logic [1:0] size);
    case (size)
      sizeByte: return 3'd1;
      sizeHalf: return 3'd2;
      sizeWord: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/aftab_load_extender.sv
// ---------------------------------------------------------------------------
// aftab_load_extender
//   Combinational sign/zero extension of a little-endian assembled load.
//   Ports:
//     assembled  in  32  bytes collected from memory, byte0 = bits[7:0]
//     size       in  2   size code (byte / half / word, 2'b11 = word)
//     signedLoad in  1   1 = replicate MSB of the top byte, 0 = zero fill
//     result     out 32  extended load value
// ---------------------------------------------------------------------------
module aftab_load_extender
  import aftab_memory_byte_sequencer_pkg::*;
(
  input  logic [31:0] assembled,
  input  logic [1:0]  size,
  input  logic        signedLoad,
  output logic [31:0] result
);

  always_comb begin
    result = assembled;
    case (size)
      sizeByte: result = {{24{signedLoad & assembled[7]}}, assembled[7:0]};
      sizeHalf: result = {{16{signedLoad & assembled[15]}}, assembled[15:0]};
      default:  result = assembled;
    endcase
  end

endmodule

// File: rtl/aftab_memory_byte_sequencer.sv
// ---------------------------------------------------------------------------
// aftab_memory_byte_sequencer
//   Upstream master for the byte-wide AFTAB memory model. One core load or
//   store of byte/half/word is split into 1/2/4 little-endian byte accesses
//   on readmem/writemem, each completed by a memDataReady return-to-zero
//   handshake. Load bytes are reassembled and sign/zero extended.
//
//   Handshake: a strobe (readmem or writemem, never both) rises with a stable
//   addressBus/dataBusIn and stays high until memDataReady is sampled 1; the
//   strobe then drops and the next byte is not started before memDataReady
//   has been sampled 0 again. startReq is only looked at in IDLE.
//
//   Ports:
//     clk, rst            clock (rising edge), async active-high reset
//     startReq            request strobe, sampled only when idle
//     writeReq            1 = store, 0 = load
//     sizeReq             00 byte, 01 half, 10/11 word
//     signedReq           sign-extend loads narrower than a word
//     addrReq             start byte address (any alignment, wraps)
//     wdataReq            store data, byte0 = bits[7:0]
//     busy                high from accepted startReq until done
//     done                one-cycle completion pulse
//     rdataOut            extended load result, held until the next load ends
//     error               pulses with done on a handshake timeout
//     readmem, writemem   memory strobes
//     addressBus          byte address to memory
//     dataBusIn           store byte to memory
//     dataBusOut          load byte from memory
//     memDataReady        memory completion handshake
//     stateDebug          current FSM state (observability only)
//
//   Build option: define AFTAB_MEM_TIMEOUT_EN to abort a request when a
//   handshake phase lasts timeoutCycles cycles (done and error pulse
//   together). Without it the sequencer waits forever and error is 0.
//   The byte lane math assumes wordWidth = 32 and dataWidth = 8.
// ---------------------------------------------------------------------------
module aftab_memory_byte_sequencer
  import aftab_memory_byte_sequencer_pkg::*;
#(
  parameter int addressWidth  = 32,
  parameter int wordWidth     = 32,
  parameter int dataWidth     = 8,
  parameter int timeoutCycles = defaultTimeoutCycles
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    startReq,
  input  logic                    writeReq,
  input  logic [1:0]              sizeReq,
  input  logic                    signedReq,
  input  logic [addressWidth-1:0] addrReq,
  input  logic [wordWidth-1:0]    wdataReq,
  output logic                    busy,
  output logic                    done,
  output logic [wordWidth-1:0]    rdataOut,
  output logic                    error,
  output logic                    readmem,
  output logic                    writemem,
  output logic [addressWidth-1:0] addressBus,
  output logic [dataWidth-1:0]    dataBusIn,
  input  logic [dataWidth-1:0]    dataBusOut,
  input  logic                    memDataReady,
  output logic [1:0]              stateDebug
);

  if (timeoutCycles < 1) begin : gBadTimeout
    $error("timeoutCycles must be at least 1");
  end

  logic [1:0]              state;
  logic                    writeLat;
  logic [1:0]              sizeLat;
  logic                    signedLat;
  logic [addressWidth-1:0] addrLat;
  logic [wordWidth-1:0]    wdataLat;
  logic [2:0]              nBytes;
  logic [1:0]              idx;
  logic [wordWidth-1:0]    asmBytes;

  logic [1:0]              nextIdx;
  logic                    moreBytes;
  logic [wordWidth-1:0]    wdataShift;
  logic [wordWidth-1:0]    loadResult;

  assign stateDebug = state;

  // idx only advances while idx+1 < nBytes <= 4, so the 2-bit increment
  // never wraps when it is actually used.
  assign nextIdx    = idx + 2'd1;
  assign moreBytes  = ({1'b0, idx} + 3'd1) < nBytes;
  assign wdataShift = wdataLat >> {nextIdx, 3'b000};

  aftab_load_extender uExtender (
    .assembled  (asmBytes),
    .size       (sizeLat),
    .signedLoad (signedLat),
    .result     (loadResult)
  );

`ifdef AFTAB_MEM_TIMEOUT_EN
  localparam logic [31:0] waitLimit = 32'(timeoutCycles - 1);
  logic [31:0] waitCnt;
  logic        errorReg;
  assign error = errorReg;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= stateIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      readmem    <= 1'b0;
      writemem   <= 1'b0;
      addressBus <= '0;
      dataBusIn  <= '0;
      rdataOut   <= '0;
      writeLat   <= 1'b0;
      sizeLat    <= '0;
      signedLat  <= 1'b0;
      addrLat    <= '0;
      wdataLat   <= '0;
      nBytes     <= '0;
      idx        <= '0;
      asmBytes   <= '0;
`ifdef AFTAB_MEM_TIMEOUT_EN
      waitCnt    <= '0;
      errorReg   <= 1'b0;
`endif
    end else begin
      // done/error are single-cycle pulses unless re-asserted below
      done <= 1'b0;
`ifdef AFTAB_MEM_TIMEOUT_EN
      errorReg <= 1'b0;
`endif
      case (state)
        stateIdle: begin
          if (startReq) begin
            writeLat   <= writeReq;
            sizeLat    <= sizeReq;
            signedLat  <= signedReq;
            addrLat    <= addrReq;
            wdataLat   <= wdataReq;
            nBytes     <= byteCount(sizeReq);
            idx        <= '0;
            asmBytes   <= '0;
            busy       <= 1'b1;
            addressBus <= addrReq;
            dataBusIn  <= wdataReq[dataWidth-1:0];
            readmem    <= ~writeReq;
            writemem   <= writeReq;
            state      <= stateAccess;
`ifdef AFTAB_MEM_TIMEOUT_EN
            waitCnt    <= '0;
`endif
          end
        end

        stateAccess: begin
          if (memDataReady) begin
            if (!writeLat) begin
              asmBytes[{idx, 3'b000} +: dataWidth] <= dataBusOut;
            end
            readmem  <= 1'b0;
            writemem <= 1'b0;
            state    <= stateRelease;
`ifdef AFTAB_MEM_TIMEOUT_EN
            waitCnt  <= '0;
          end else if (waitCnt == waitLimit) begin
            readmem  <= 1'b0;
            writemem <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            errorReg <= 1'b1;
            state    <= stateIdle;
          end else begin
            waitCnt  <= waitCnt + 32'd1;
`endif
          end
        end

        stateRelease: begin
          // Strobes are already low; wait for the memory to return
          // memDataReady to zero before the next byte or completion.
          if (!memDataReady) begin
            if (moreBytes) begin
              idx        <= nextIdx;
              addressBus <= addrLat + addressWidth'(nextIdx);
              dataBusIn  <= wdataShift[dataWidth-1:0];
              readmem    <= ~writeLat;
              writemem   <= writeLat;
              state      <= stateAccess;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= stateFinish;
              if (!writeLat) begin
                rdataOut <= loadResult;
              end
            end
`ifdef AFTAB_MEM_TIMEOUT_EN
            waitCnt <= '0;
          end else if (waitCnt == waitLimit) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            errorReg <= 1'b1;
            state    <= stateIdle;
          end else begin
            waitCnt  <= waitCnt + 32'd1;
`endif
          end
        end

        stateFinish: begin
          state <= stateIdle;
        end

        default: begin
          state <= stateIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aftab_memory_byte_sequencer.sv
module tb_aftab_memory_byte_sequencer;

  logic        clk;
  logic        rst;
  logic        startReq;
  logic        writeReq;
  logic [1:0]  sizeReq;
  logic        signedReq;
  logic [31:0] addrReq;
  logic [31:0] wdataReq;
  logic        busy;
  logic        done;
  logic [31:0] rdataOut;
  logic        error;
  logic        readmem;
  logic        writemem;
  logic [31:0] addressBus;
  logic [7:0]  dataBusIn;
  logic [7:0]  dataBusOut;
  logic        memDataReady;
  logic [1:0]  stateDebug;

  aftab_memory_byte_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .startReq     (startReq),
    .writeReq     (writeReq),
    .sizeReq      (sizeReq),
    .signedReq    (signedReq),
    .addrReq      (addrReq),
    .wdataReq     (wdataReq),
    .busy         (busy),
    .done         (done),
    .rdataOut     (rdataOut),
    .error        (error),
    .readmem      (readmem),
    .writemem     (writemem),
    .addressBus   (addressBus),
    .dataBusIn    (dataBusIn),
    .dataBusOut   (dataBusOut),
    .memDataReady (memDataReady),
    .stateDebug   (stateDebug)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared bench state ----------------
  int nChecks;
  int nFail;
  int maxDelay;
  int delaySum;
  logic [32:0] exp_q[$];            // expected {write, address} per byte access
  logic [7:0]  mem    [logic [31:0]];  // memory seen by the DUT
  logic [7:0]  refMem [logic [31:0]];  // reference contents from request semantics

  function automatic logic [7:0] memRd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] refRd(input logic [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return 8'h00;
  endfunction

  function automatic int bytesFor(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  // Expected load value: little-endian integer, then two's-complement
  // reinterpretation for signed narrow loads.
  function automatic logic [31:0] expLoad(input logic [31:0] a, input logic [1:0] sz, input bit sg);
    int n;
    longint v;
    n = bytesFor(sz);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(refRd(a + 32'(i))) << (8 * i);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- memory responder ----------------
  initial begin : responder
    int phase;
    int cnt;
    logic [32:0] e;
    logic [31:0] rAddr;
    logic [7:0]  rData;
    bit          rWr;
    phase = 0;
    cnt = 0;
    rAddr = '0;
    rData = '0;
    rWr = 1'b0;
    memDataReady = 1'b0;
    dataBusOut = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        phase = 0;
        memDataReady = 1'b0;
      end else begin
        nChecks++;
        if (readmem && writemem) begin
          nFail++;
          $display("FAIL strobe_exclusive: readmem=%b writemem=%b both high", readmem, writemem);
        end
        if (phase == 0 && (readmem || writemem)) begin
          rAddr = addressBus;
          rData = dataBusIn;
          rWr = writemem;
          nChecks++;
          if (exp_q.size() == 0) begin
            nFail++;
            $display("FAIL access_unexpected: got write=%b addr=%h, required no access", writemem, addressBus);
          end else begin
            e = exp_q.pop_front();
            if ({writemem, addressBus} !== e) begin
              nFail++;
              $display("FAIL access_order: got write=%b addr=%h, required write=%b addr=%h",
                       writemem, addressBus, e[32], e[31:0]);
            end
          end
          cnt = $urandom_range(0, maxDelay);
          delaySum += cnt;
          phase = 1;
        end else if (phase == 1 || (phase == 2 && (readmem || writemem))) begin
          nChecks++;
          if ({readmem, writemem, addressBus, dataBusIn} !== {~rWr, rWr, rAddr, rData}) begin
            nFail++;
            $display("FAIL strobe_stable: got rd=%b wr=%b addr=%h data=%h, required rd=%b wr=%b addr=%h data=%h",
                     readmem, writemem, addressBus, dataBusIn, ~rWr, rWr, rAddr, rData);
          end
        end else if (phase == 2) begin
          memDataReady = 1'b0;
          dataBusOut = 8'($urandom);
          phase = 0;
        end
        if (phase == 1) begin
          if (cnt == 0) begin
            if (rWr) mem[rAddr] = rData;
            else dataBusOut = memRd(rAddr);
            memDataReady = 1'b1;
            phase = 2;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one request and follows it to done. Optionally pulses a junk
  // startReq while busy, which must be ignored.
  task automatic doReq(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] wd, input bit pulseDuring, output logic [31:0] res);
    int n;
    int cycles;
    int expCycles;
    bit seenDone;
    logic [31:0] prevRdata;
    n = bytesFor(sz);
    res = 'x;
    for (int i = 0; i < n; i++) exp_q.push_back({wr, a + 32'(i)});
    @(negedge clk);
    prevRdata = rdataOut;
    delaySum = 0;
    startReq = 1'b1; writeReq = wr; sizeReq = sz; signedReq = sg; addrReq = a; wdataReq = wd;
    @(posedge clk);
    #1;
    startReq = 1'b0;
    addrReq = $urandom; wdataReq = $urandom; sizeReq = 2'($urandom); signedReq = ~sg; writeReq = ~wr;
    cycles = 0;
    seenDone = 1'b0;
    for (int c = 0; c < 400 && !seenDone; c++) begin
      @(negedge clk);
      startReq = 1'b0;
      nChecks++;
      if (done) begin
        seenDone = 1'b1;
        res = rdataOut;
        if (busy !== 1'b0 || error !== 1'b0) begin
          nFail++;
          $display("FAIL done_flags: got busy=%b error=%b at done, required 0 0", busy, error);
        end
      end else begin
        cycles++;
        if (busy !== 1'b1) begin
          nFail++;
          $display("FAIL busy_hold: got busy=%b before done, required 1", busy);
        end
        if (pulseDuring && c == 1) begin
          startReq = 1'b1;
          addrReq = 32'h0000_0F00;
          writeReq = 1'b1;
        end
      end
    end
    nChecks++;
    if (!seenDone) begin
      nFail++;
      $display("FAIL done_timeout: no done within 400 cycles, required one done");
    end
    expCycles = 2 * n + delaySum;
    nChecks++;
    if (cycles !== expCycles) begin
      nFail++;
      $display("FAIL latency: got %0d cycles, required %0d", cycles, expCycles);
    end
    @(negedge clk);
    nChecks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nFail++;
      $display("FAIL after_done: got done=%b busy=%b, required 0 0", done, busy);
    end
    nChecks++;
    if (exp_q.size() != 0) begin
      nFail++;
      $display("FAIL access_count: %0d accesses missing, required 0", exp_q.size());
      exp_q.delete();
    end
    if (wr) begin
      for (int i = 0; i < n; i++) refMem[a + 32'(i)] = 8'(wd >> (8 * i));
      for (int i = 0; i < n; i++) begin
        nChecks++;
        if (memRd(a + 32'(i)) !== refRd(a + 32'(i))) begin
          nFail++;
          $display("FAIL store_byte: addr=%h got %h, required %h", a + 32'(i), memRd(a + 32'(i)), refRd(a + 32'(i)));
        end
      end
      nChecks++;
      if (res !== prevRdata) begin
        nFail++;
        $display("FAIL store_rdata: got rdataOut=%h, required unchanged %h", res, prevRdata);
      end
    end else begin
      nChecks++;
      if (res !== expLoad(a, sz, sg)) begin
        nFail++;
        $display("FAIL load_value: addr=%h size=%0d signed=%b got %h, required %h", a, sz, sg, res, expLoad(a, sz, sg));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nChecks++;
    if ({busy, done, error, readmem, writemem} !== 5'b0) begin
      nFail++;
      $display("FAIL reset_flags: got busy/done/error/rd/wr=%b, required 00000", {busy, done, error, readmem, writemem});
    end
    nChecks++;
    if (addressBus !== 32'h0 || dataBusIn !== 8'h0 || rdataOut !== 32'h0) begin
      nFail++;
      $display("FAIL reset_buses: got addr=%h data=%h rdata=%h, required 0 0 0", addressBus, dataBusIn, rdataOut);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] r;
    logic [7:0] got;
    maxDelay = 0;
    doReq(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0, r);
    got = memRd(32'h10);
    nChecks++;
    if ({memRd(32'h10), memRd(32'h11), memRd(32'h12), memRd(32'h13)} !== 32'h4433_2211) begin
      nFail++;
      $display("FAIL word_bytes: got %h %h %h %h, required 44 33 22 11", got, memRd(32'h11), memRd(32'h12), memRd(32'h13));
    end
    doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, r);
    nChecks++;
    if (r !== 32'h1122_3344) begin nFail++; $display("FAIL word_load: got %h, required 11223344", r); end
    maxDelay = 3;
    doReq(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_0080, 1'b0, r);
    doReq(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0, r);
    nChecks++;
    if (r !== 32'hFFFF_FF80) begin nFail++; $display("FAIL byte_signed: got %h, required ffffff80", r); end
    doReq(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, r);
    nChecks++;
    if (r !== 32'h0000_0080) begin nFail++; $display("FAIL byte_unsigned: got %h, required 00000080", r); end
    doReq(1'b1, 2'b01, 1'b0, 32'h0FFF, 32'h0000_BEEF, 1'b0, r);
    nChecks++;
    if (memRd(32'h0FFF) !== 8'hEF || memRd(32'h1000) !== 8'hBE) begin
      nFail++;
      $display("FAIL half_cross: got %h %h, required ef be", memRd(32'h0FFF), memRd(32'h1000));
    end
    doReq(1'b0, 2'b01, 1'b1, 32'h0FFF, 32'h0, 1'b0, r);
    nChecks++;
    if (r !== 32'hFFFF_BEEF) begin nFail++; $display("FAIL half_signed: got %h, required ffffbeef", r); end
    doReq(1'b1, 2'b11, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b0, r);
    doReq(1'b0, 2'b11, 1'b1, 32'h40, 32'h0, 1'b0, r);
    nChecks++;
    if (r !== 32'hCAFE_F00D) begin nFail++; $display("FAIL size3_word: got %h, required cafef00d", r); end
    doReq(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 1'b0, r);
    nChecks++;
    if (memRd(32'hFFFF_FFFF) !== 8'hC3 || memRd(32'h0) !== 8'hB2) begin
      nFail++;
      $display("FAIL addr_wrap: got %h %h, required c3 b2", memRd(32'hFFFF_FFFF), memRd(32'h0));
    end
    doReq(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0, r);
    nChecks++;
    if (r !== 32'hA1B2_C3D4) begin nFail++; $display("FAIL wrap_load: got %h, required a1b2c3d4", r); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] r;
    maxDelay = 2;
    doReq(1'b1, 2'b10, 1'b0, 32'h80, 32'h0BAD_F00D, 1'b1, r);
    doReq(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1, r);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    bit seen;
    maxDelay = 3;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 32'h10 + 32'(i)});
    @(negedge clk);
    startReq = 1'b1; writeReq = 1'b0; sizeReq = 2'b10; signedReq = 1'b0; addrReq = 32'h10;
    @(negedge clk);
    startReq = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (readmem && dut.addressBus == 32'h11) seen = 1'b1;
      else @(negedge clk);
    end
    nChecks++;
    if (!seen) begin nFail++; $display("FAIL midreset_setup: readmem on 2nd byte not seen, required high"); end
    #2;
    rst = 1'b1;
    #1;
    nChecks++;
    if (readmem !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      nFail++;
      $display("FAIL midreset_async: got rd=%b busy=%b done=%b, required 0 0 0", readmem, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nChecks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        nFail++;
        $display("FAIL midreset_quiet: got done=%b busy=%b, required 0 0", done, busy);
      end
    end
    doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, r);
    nChecks++;
    if (r !== 32'h1122_3344) begin nFail++; $display("FAIL midreset_next: got %h, required 11223344", r); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] lastStore;
    bit wr;
    lastStore = 32'h10;
    for (int i = 0; i < 40; i++) begin
      maxDelay = $urandom_range(0, 3);
      wr = 1'($urandom);
      if ($urandom_range(0, 1) == 1) a = lastStore;
      else if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, 32'h1FFF));
      if (wr) lastStore = a;
      doReq(wr, 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom_range(0, 3) == 0), r);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    nChecks = 0;
    nFail = 0;
    maxDelay = 0;
    delaySum = 0;
    rst = 1'b1;
    startReq = 1'b0; writeReq = 1'b0; sizeReq = 2'b00; signedReq = 1'b0;
    addrReq = '0; wdataReq = '0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
